pcileech_com_rx_demux: RTL and testbench

Consumes the 64-bit command word stream delivered by the communication core into the FIFO interface and routes each word to one of four destinations: the PCIe TLP path, the config/DRP path, the loopback TX path, or the command register strobe. Words arrive as a push-only stream with no backpressure, so the block buffers them in a shallow FIFO. It packs TLP dwords into 128-bit beats and keeps overflow and bad-magic statistics. It sits between the COM RX output and the FIFO-control/PCIe consumers, in the 100 MHz system clock domain.

---
 rtl/pcileech_com_pkg.sv | 29 ++
 rtl/pcileech_com_rx_fifo.sv | 52 +++++
 rtl/pcileech_com_rx_demux.sv | 200 ++++++++++++++++++++
 tb/tb_pcileech_com_rx_demux.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_com_pkg.sv
// Shared definitions for the COM RX command word: target codes, field offsets
// and the default magic value.
package pcileech_com_pkg;

  typedef enum logic [1:0] {
    TGT_TLP  = 2'd0,
    TGT_CFG  = 2'd1,
    TGT_LPBK = 2'd2,
    TGT_CMD  = 2'd3
  } com_tgt_t;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned MAGIC_LSB = 0;
  localparam int unsigned MAGIC_W   = 8;
  localparam int unsigned TGT_LSB   = 8;
  localparam int unsigned TGT_W     = 2;
  localparam int unsigned LAST_BIT  = 10;
  localparam int unsigned AUX_LSB   = 16;
  localparam int unsigned AUX_W     = 16;
  localparam int unsigned PAY_LSB   = 32;
  localparam int unsigned PAY_W     = 32;

  localparam logic [7:0] MAGIC_DEFAULT = 8'h77;

  function automatic com_tgt_t word_tgt(input logic [WORD_W-1:0] w);
    return com_tgt_t'(w[TGT_LSB +: TGT_W]);
  endfunction

endpackage

// File: rtl/pcileech_com_rx_fifo.sv
// Shallow synchronous word FIFO with count-based full/empty; the head word is
// read straight from the storage flops so it is visible the cycle after a push.
module pcileech_com_rx_fifo
  import pcileech_com_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/pcileech_com_rx_demux.sv
// Routes buffered COM RX command words to the TLP packer, CFG, loopback and
// command strobe outputs, and keeps overflow / bad-magic statistics.
module pcileech_com_rx_demux
  import pcileech_com_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  MAGIC      = MAGIC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   in_data,
  input  logic          in_valid,
  output logic [127:0]  tlp_data,
  output logic [3:0]    tlp_keep,
  output logic          tlp_last,
  output logic          tlp_valid,
  input  logic          tlp_ready,
  output logic [63:0]   cfg_data,
  output logic          cfg_valid,
  input  logic          cfg_ready,
  output logic [31:0]   lpbk_data,
  output logic          lpbk_valid,
  input  logic          lpbk_ready,
  output logic [15:0]   cmd_addr,
  output logic [31:0]   cmd_data,
  output logic          cmd_valid,
  output logic          ovf,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   bad_magic_cnt
);

  typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} pack_st_t;

  logic [WORD_W-1:0] w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_pop_tlp;
  logic              w_pop_cfg;
  logic              w_pop_lpbk;
  logic              w_pop_cmd;
  logic              w_bad;
  logic [PAY_W-1:0]  w_pay;
  logic              w_last;

  pack_st_t          r_state;
  logic [1:0]        r_idx;
  logic [127:0]      r_tlp_data;
  logic [3:0]        r_tlp_keep;
  logic              r_tlp_last;
  logic              r_tlp_valid;
  logic [63:0]       r_cfg_data;
  logic              r_cfg_valid;
  logic [31:0]       r_lpbk_data;
  logic              r_lpbk_valid;
  logic [15:0]       r_cmd_addr;
  logic [31:0]       r_cmd_data;
  logic              r_cmd_valid;
  logic              r_ovf;
  logic [15:0]       r_drop_cnt;
  logic [15:0]       r_bad_cnt;

  pcileech_com_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_pay  = w_head[PAY_LSB +: PAY_W];
  assign w_last = w_head[LAST_BIT];

  // Head pop decision: bad magic always drains, otherwise wait for the target.
  always_comb begin
    w_pop      = 1'b0;
    w_pop_tlp  = 1'b0;
    w_pop_cfg  = 1'b0;
    w_pop_lpbk = 1'b0;
    w_pop_cmd  = 1'b0;
    w_bad      = 1'b0;
    if (!w_empty) begin
      if (w_head[MAGIC_LSB +: MAGIC_W] != MAGIC) begin
        w_bad = 1'b1;
      end else begin
        unique case (word_tgt(w_head))
          TGT_TLP:  w_pop_tlp  = (r_state == ST_ACC);
          TGT_CFG:  w_pop_cfg  = !r_cfg_valid || cfg_ready;
          TGT_LPBK: w_pop_lpbk = !r_lpbk_valid || lpbk_ready;
          TGT_CMD:  w_pop_cmd  = 1'b1;
        endcase
      end
      w_pop = w_bad || w_pop_tlp || w_pop_cfg || w_pop_lpbk || w_pop_cmd;
    end
  end

  // TLP packer: accumulate up to four dwords, then present the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_idx       <= 2'd0;
      r_tlp_data  <= '0;
      r_tlp_keep  <= '0;
      r_tlp_last  <= 1'b0;
      r_tlp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_pop_tlp) begin
            r_tlp_data[{r_idx, 5'd0} +: 32] <= w_pay;
            r_tlp_keep[r_idx]               <= 1'b1;
            if (w_last || r_idx == 2'd3) begin
              r_state     <= ST_OUT;
              r_tlp_last  <= w_last;
              r_tlp_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        ST_OUT: begin
          if (tlp_ready) begin
            r_state     <= ST_ACC;
            r_idx       <= 2'd0;
            r_tlp_data  <= '0;
            r_tlp_keep  <= '0;
            r_tlp_last  <= 1'b0;
            r_tlp_valid <= 1'b0;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

  // CFG / loopback output registers and the command strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_data   <= '0;
      r_cfg_valid  <= 1'b0;
      r_lpbk_data  <= '0;
      r_lpbk_valid <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_data   <= '0;
      r_cmd_valid  <= 1'b0;
    end else begin
      if (w_pop_cfg) begin
        r_cfg_data  <= w_head;
        r_cfg_valid <= 1'b1;
      end else if (cfg_ready) begin
        r_cfg_valid <= 1'b0;
      end
      if (w_pop_lpbk) begin
        r_lpbk_data  <= w_pay;
        r_lpbk_valid <= 1'b1;
      end else if (lpbk_ready) begin
        r_lpbk_valid <= 1'b0;
      end
      r_cmd_valid <= w_pop_cmd;
      if (w_pop_cmd) begin
        r_cmd_addr <= w_head[AUX_LSB +: AUX_W];
        r_cmd_data <= w_pay;
      end
    end
  end

  // Statistics: sticky overflow and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      if (in_valid && w_full) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_bad && r_bad_cnt != 16'hFFFF) r_bad_cnt <= r_bad_cnt + 16'd1;
    end
  end

  assign tlp_data      = r_tlp_data;
  assign tlp_keep      = r_tlp_keep;
  assign tlp_last      = r_tlp_last;
  assign tlp_valid     = r_tlp_valid;
  assign cfg_data      = r_cfg_data;
  assign cfg_valid     = r_cfg_valid;
  assign lpbk_data     = r_lpbk_data;
  assign lpbk_valid    = r_lpbk_valid;
  assign cmd_addr      = r_cmd_addr;
  assign cmd_data      = r_cmd_data;
  assign cmd_valid     = r_cmd_valid;
  assign ovf           = r_ovf;
  assign drop_cnt      = r_drop_cnt;
  assign bad_magic_cnt = r_bad_cnt;

endmodule

// File: tb/tb_pcileech_com_rx_demux.sv
// Scoreboard bench for pcileech_com_rx_demux: expected outputs are queued as
// words are driven and compared whenever an output handshake occurs.
module tb_pcileech_com_rx_demux;

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic [127:0] tlp_data;
  logic [3:0]   tlp_keep;
  logic         tlp_last;
  logic         tlp_valid;
  logic         tlp_ready = 1'b1;
  logic [63:0]  cfg_data;
  logic         cfg_valid;
  logic         cfg_ready = 1'b1;
  logic [31:0]  lpbk_data;
  logic         lpbk_valid;
  logic         lpbk_ready = 1'b1;
  logic [15:0]  cmd_addr;
  logic [31:0]  cmd_data;
  logic         cmd_valid;
  logic         ovf;
  logic [15:0]  drop_cnt;
  logic [15:0]  bad_magic_cnt;

  int n_checks = 0;
  int n_errors = 0;

  beat_t        q_tlp[$];
  logic [63:0]  q_cfg[$];
  logic [31:0]  q_lpbk[$];
  logic [47:0]  q_cmd[$];

  pcileech_com_rx_demux #(.FIFO_DEPTH(16), .MAGIC(8'h77)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .tlp_data(tlp_data), .tlp_keep(tlp_keep), .tlp_last(tlp_last),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .lpbk_data(lpbk_data), .lpbk_valid(lpbk_valid), .lpbk_ready(lpbk_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .ovf(ovf), .drop_cnt(drop_cnt), .bad_magic_cnt(bad_magic_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tlp_valid && tlp_ready) begin
        if (q_tlp.size() == 0) check("tlp_unexpected", 136'(tlp_keep), 136'(0));
        else check("tlp_beat", 136'({tlp_data, tlp_keep, tlp_last}), 136'(q_tlp.pop_front()));
      end
      if (cfg_valid && cfg_ready) begin
        if (q_cfg.size() == 0) check("cfg_unexpected", 136'(cfg_data), 136'(0));
        else check("cfg_data", 136'(cfg_data), 136'(q_cfg.pop_front()));
      end
      if (lpbk_valid && lpbk_ready) begin
        if (q_lpbk.size() == 0) check("lpbk_unexpected", 136'(lpbk_data), 136'(0));
        else check("lpbk_data", 136'(lpbk_data), 136'(q_lpbk.pop_front()));
      end
      if (cmd_valid) begin
        if (q_cmd.size() == 0) check("cmd_unexpected", 136'({cmd_addr, cmd_data}), 136'(0));
        else check("cmd", 136'({cmd_addr, cmd_data}), 136'(q_cmd.pop_front()));
      end
    end
  end

  task automatic send_raw(input logic [63:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] tgt, input logic [31:0] pay, input logic last,
                      input logic [15:0] aux, input logic [7:0] magic);
    send_raw({pay, aux, 5'd0, last, tgt, magic});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int left;
    for (int i = 0; i < 300; i++) begin
      left = q_tlp.size() + q_cfg.size() + q_lpbk.size() + q_cmd.size();
      if (left == 0) break;
      @(posedge clk); #1;
    end
    cycles(3);
    left = q_tlp.size() + q_cfg.size() + q_lpbk.size() + q_cmd.size();
    check(tag, 136'(left), 136'(0));
  endtask

  initial begin
    beat_t b;
    cycles(3);
    check("rst_tlp_valid", 136'(tlp_valid), 136'(0));
    check("rst_tlp_keep",  136'({tlp_keep, tlp_last}), 136'(0));
    check("rst_valids",    136'({cfg_valid, lpbk_valid, cmd_valid}), 136'(0));
    check("rst_data",      136'({cfg_data, lpbk_data, cmd_addr}), 136'(0));
    check("rst_stats",     136'({ovf, drop_cnt, bad_magic_cnt}), 136'(0));
    @(negedge clk) rst_n = 1'b1;
    cycles(2);

    // Single CFG word, latency n+2, one-cycle valid.
    q_cfg.push_back(64'h00000003_80182177);
    send_raw(64'h00000003_80182177);
    check("cfg_lat_n1", 136'(cfg_valid), 136'(0));
    cycles(1);
    check("cfg_lat_n2", 136'(cfg_valid), 136'(1));
    check("cfg_lat_data", 136'(cfg_data), 136'(64'h00000003_80182177));
    cycles(1);
    check("cfg_one_cycle", 136'(cfg_valid), 136'(0));
    wait_drain("drain_cfg");

    // Three-dword TLP.
    b.d = {32'h0, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}; b.k = 4'b0111; b.l = 1'b1;
    q_tlp.push_back(b);
    send(2'd0, 32'hAAAA0001, 1'b0, 16'h0, 8'h77);
    send(2'd0, 32'hBBBB0002, 1'b0, 16'h0, 8'h77);
    send(2'd0, 32'hCCCC0003, 1'b1, 16'h0, 8'h77);
    check("tlp_lat_n1", 136'(tlp_valid), 136'(0));
    cycles(1);
    check("tlp_lat_n2", 136'({tlp_valid, tlp_keep}), 136'({1'b1, 4'b0111}));
    wait_drain("drain_tlp3");

    // Five-dword TLP spanning two beats.
    b.d = {32'h4, 32'h3, 32'h2, 32'h1}; b.k = 4'hF; b.l = 1'b0;
    q_tlp.push_back(b);
    b.d = {96'h0, 32'h5}; b.k = 4'b0001; b.l = 1'b1;
    q_tlp.push_back(b);
    for (int i = 1; i <= 5; i++) send(2'd0, 32'(i), (i == 5), 16'h0, 8'h77);
    wait_drain("drain_tlp5");

    // Interleaved non-TLP words leave the packer's accumulation alone.
    b.d = {64'h0, 32'h0000BEEF, 32'h0000DEAD}; b.k = 4'b0011; b.l = 1'b1;
    q_tlp.push_back(b);
    q_cfg.push_back({32'h12345678, 16'h00AB, 5'd0, 1'b0, 2'd1, 8'h77});
    q_lpbk.push_back(32'hCAFEF00D);
    q_cmd.push_back({16'h0042, 32'h87654321});
    send(2'd0, 32'h0000DEAD, 1'b0, 16'h0, 8'h77);
    send(2'd1, 32'h12345678, 1'b0, 16'h00AB, 8'h77);
    send(2'd0, 32'h0000BEEF, 1'b1, 16'h0, 8'h77);
    send(2'd2, 32'hCAFEF00D, 1'b0, 16'h0, 8'h77);
    send(2'd3, 32'h87654321, 1'b0, 16'h0042, 8'h77);
    wait_drain("drain_mix");

    // Overflow: 17 words fit (16 buffered + output register), 3 dropped.
    lpbk_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 17) q_lpbk.push_back(32'h1000 + 32'(i));
      send(2'd2, 32'h1000 + 32'(i), 1'b0, 16'h0, 8'h77);
    end
    cycles(2);
    check("ovf_drop_cnt", 136'(drop_cnt), 136'(3));
    check("ovf_flag", 136'(ovf), 136'(1));
    check("ovf_held", 136'({lpbk_valid, lpbk_data}), 136'({1'b1, 32'h1000}));
    lpbk_ready = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_sticky", 136'(ovf), 136'(1));

    // Bad magic word discarded, then a command strobe.
    q_cmd.push_back({16'h0018, 32'h1});
    send(2'd1, 32'hDEADDEAD, 1'b0, 16'h0, 8'h55);
    send(2'd3, 32'h1, 1'b0, 16'h0018, 8'h77);
    wait_drain("drain_cmd");
    check("bad_magic_cnt", 136'(bad_magic_cnt), 136'(1));

    // Asynchronous reset with a partial TLP held in the packer.
    send(2'd0, 32'h11111111, 1'b0, 16'h0, 8'h77);
    send(2'd0, 32'h22222222, 1'b0, 16'h0, 8'h77);
    cycles(3);
    check("partial_keep", 136'({tlp_valid, tlp_keep}), 136'({1'b0, 4'b0011}));
    rst_n = 1'b0;
    #1;
    check("arst_tlp", 136'({tlp_valid, tlp_keep, tlp_data}), 136'(0));
    check("arst_stats", 136'({ovf, drop_cnt, bad_magic_cnt}), 136'(0));
    @(negedge clk) rst_n = 1'b1;
    cycles(2);
    b.d = {96'h0, 32'h33333333}; b.k = 4'b0001; b.l = 1'b1;
    q_tlp.push_back(b);
    send(2'd0, 32'h33333333, 1'b1, 16'h0, 8'h77);
    cycles(1);
    check("post_rst_keep", 136'({tlp_valid, tlp_keep}), 136'({1'b1, 4'b0001}));
    wait_drain("drain_post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
